// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ valid/ready producers.
// A grant is held for up to MAX_BURST beats, released early when the owner drops valid.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wr_en,
    output logic [DATA_WIDTH-1:0]               fifo_din,
    output logic                                grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id,
    output logic [$clog2(MAX_BURST+1)-1:0]      burst_cnt
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;

    logic              owner_valid;
    logic              beat;
    logic              last_beat;
    logic              release_c;
    logic [ID_W-1:0]   ptr_after;
    logic [ID_W-1:0]   arb_ptr;
    logic              arb_hit;
    logic [ID_W-1:0]   arb_id;

    // Index k positions after base, wrapping at NUM_REQ (need not be a power of two).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int unsigned k);
        return ID_W'((32'(base) + k) % NUM_REQ);
    endfunction

    assign grant_valid = (state == OWN);
    assign owner_valid = req_valid[grant_id];
    assign beat        = grant_valid & owner_valid & ~fifo_full;
    assign last_beat   = beat && (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign release_c   = grant_valid & (last_beat | ~owner_valid);
    assign ptr_after   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // On a release edge the search starts just past the outgoing owner.
    assign arb_ptr = release_c ? ptr_after : rr_ptr;

    // First valid requester at or after arb_ptr.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = arb_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!arb_hit && req_valid[rr_index(arb_ptr, k)]) begin
                arb_hit = 1'b1;
                arb_id  = rr_index(arb_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        state     <= OWN;
                        grant_id  <= arb_id;
                        burst_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_c) begin
                        rr_ptr    <= ptr_after;
                        burst_cnt <= '0;
                        if (arb_hit) begin
                            grant_id <= arb_id;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-side outputs follow the registered owner; nothing is accepted while full.
    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_id] = ~fifo_full;
        end
    end

    assign fifo_wr_en = beat;

    always_comb begin
        fifo_din = '0;
        if (grant_valid) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_W'(i)) begin
                    fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected FIFO writes are queued by the stimulus
// and checked by an independent monitor; grant/burst status is checked inline.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [2:0]  burst_cnt;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_cnt   (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    logic [7:0]  mem [4][32];
    int          rd [4];
    int          wr [4];
    logic [3:0]  fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (wr[i] != rd[i]);
            req_data[i*8 +: 8] = (wr[i] != rd[i]) ? mem[i][rd[i]] : 8'h00;
        end
    endtask

    task automatic load(input int i, input logic [7:0] d);
        mem[i][wr[i]] = d;
        wr[i]++;
    endtask

    // One clock: capture handshakes before the edge, retire accepted words after it.
    task automatic step();
        #1;
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) rd[i]++;
        drive();
        #1;
    endtask

    // Write monitor: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (fifo_wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL wr_in_reset: got %b expected 0 at %0t", fifo_wr_en, $time);
            end
        end else if (fifo_wr_en) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got 0x%0h expected none at %0t", fifo_din, $time);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (fifo_din !== e) begin
                    n_err++;
                    $display("FAIL write_data: got 0x%0h expected 0x%0h at %0t", fifo_din, e, $time);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;

        // Reset with everyone valid; then owners 0,1,2,3,0 for 4 beats each.
        for (int j = 0; j < 8; j++) load(0, 8'hA0);
        for (int i = 1; i < 4; i++) for (int j = 0; j < 4; j++) load(i, 8'hA0 + 8'(i));
        drive();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_grant_valid", 32'(grant_valid), 32'h0);
        rst = 1'b0;
        chk("post_rst_idle", 32'(grant_valid), 32'h0);
        for (int b = 0; b < 5; b++) for (int j = 0; j < 4; j++) sb.push_back(8'hA0 + 8'(b % 4));
        step();
        chk("first_grant_valid", 32'(grant_valid), 32'h1);
        chk("first_grant_id", 32'(grant_id), 32'h0);
        for (int c = 0; c < 20; c++) begin
            chk("rr_wr_en", 32'(fifo_wr_en), 32'h1);
            chk("rr_owner", 32'(grant_id), 32'((c / 4) % 4));
            chk("rr_burst", 32'(burst_cnt), 32'(c % 4));
            step();
        end
        step();
        step();
        chk("rr_idle", 32'(grant_valid), 32'h0);

        // Sole requester 1: ten back-to-back words, regranted at each burst limit.
        for (int j = 0; j < 10; j++) begin
            load(1, 8'h10 + 8'(j));
            sb.push_back(8'h10 + 8'(j));
        end
        drive();
        #1;
        chk("solo_latency", 32'(grant_valid), 32'h0);
        step();
        for (int c = 0; c < 10; c++) begin
            chk("solo_wr_en", 32'(fifo_wr_en), 32'h1);
            chk("solo_owner", 32'(grant_id), 32'h1);
            chk("solo_burst", 32'(burst_cnt), 32'(c % 4));
            step();
        end
        chk("solo_drop_no_write", 32'(fifo_wr_en), 32'h0);
        step();
        step();
        chk("solo_idle", 32'(grant_valid), 32'h0);

        // Owner 0 stalled by a full FIFO at burst_cnt=2.
        for (int j = 0; j < 4; j++) begin
            load(0, 8'h40 + 8'(j));
            sb.push_back(8'h40 + 8'(j));
        end
        drive();
        step();
        chk("full_owner", 32'(grant_id), 32'h0);
        step();
        step();
        chk("full_pre_burst", 32'(burst_cnt), 32'h2);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("full_ready", 32'(req_ready), 32'h0);
            chk("full_burst_hold", 32'(burst_cnt), 32'h2);
            chk("full_owner_hold", 32'(grant_id), 32'h0);
            step();
        end
        fifo_full = 1'b0;
        #1;
        chk("full_resume_wr", 32'(fifo_wr_en), 32'h1);
        step();
        chk("full_resume_burst", 32'(burst_cnt), 32'h3);
        step();
        step();
        step();
        chk("full_idle", 32'(grant_valid), 32'h0);

        // Owner 1 drops valid after 2 beats; requesters 0 and 3 pending.
        load(1, 8'h51);
        load(1, 8'h52);
        load(0, 8'h50);
        load(3, 8'h53);
        sb.push_back(8'h51);
        sb.push_back(8'h52);
        sb.push_back(8'h53);
        sb.push_back(8'h50);
        drive();
        step();
        chk("drop_owner", 32'(grant_id), 32'h1);
        step();
        step();
        chk("drop_bubble", 32'(fifo_wr_en), 32'h0);
        step();
        chk("drop_next_owner", 32'(grant_id), 32'h3);
        chk("drop_next_wr", 32'(fifo_wr_en), 32'h1);
        chk("drop_next_burst", 32'(burst_cnt), 32'h0);
        step();
        step();
        chk("drop_wrap_owner", 32'(grant_id), 32'h0);
        step();
        step();
        chk("drop_idle", 32'(grant_valid), 32'h0);

        // Reset pulse while owner 2 is at burst_cnt=1.
        for (int j = 0; j < 4; j++) load(2, 8'h60 + 8'(j));
        sb.push_back(8'h60);
        drive();
        step();
        chk("rstp_owner", 32'(grant_id), 32'h2);
        step();
        chk("rstp_burst", 32'(burst_cnt), 32'h1);
        load(0, 8'h70);
        load(1, 8'h71);
        load(3, 8'h73);
        drive();
        rst = 1'b1;
        #1;
        chk("rstp_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rstp_grant_valid", 32'(grant_valid), 32'h0);
        chk("rstp_burst_clr", 32'(burst_cnt), 32'h0);
        step();
        rst = 1'b0;
        sb.push_back(8'h70);
        sb.push_back(8'h71);
        sb.push_back(8'h61);
        sb.push_back(8'h62);
        sb.push_back(8'h63);
        sb.push_back(8'h73);
        step();
        chk("rstp_new_owner", 32'(grant_id), 32'h0);
        chk("rstp_new_burst", 32'(burst_cnt), 32'h0);
        for (int c = 0; c < 12; c++) step();
        chk("rstp_idle", 32'(grant_valid), 32'h0);

        #4;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
